// File: rtl/pll_clkgen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pll_clkgen_pkg
//  Description : Shared constants for the digital PLL stand-in: the legal
//                divide-ratio range and the counter widths used by the
//                dividers and the lock counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package pll_clkgen_pkg;

    // Legal divide-ratio range for each output divider
    localparam int DIV_MIN  = 2;
    localparam int DIV_MAX  = 1023;

    // Counter widths: DIV_W holds 0..DIV_MAX-1, LOCK_W holds 0..LOCK_MAX
    localparam int DIV_W    = 10;
    localparam int LOCK_W   = 16;
    localparam int LOCK_MAX = 65535;

endpackage : pll_clkgen_pkg
`default_nettype wire

// File: rtl/pll_clk_div.sv
`default_nettype none
// ============================================================================
//  Module      : pll_clk_div
//  Description : Integer clock divider with a registered, glitch-free output.
//                Counter c runs 0..DIV-1; the output is high while
//                c < DIV/2, so odd ratios give floor(DIV/2) high cycles.
//                While en is low the counter and output are held at 0, so
//                the first cycle after en rises starts a full high phase.
//  Ports       : clk   - input clock (all logic on its rising edge)
//                rst_n - asynchronous active-low reset
//                en    - divider enable (held low until the PLL reports lock)
//                clk_o - divided clock output
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_clk_div
    import pll_clkgen_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic clk_o
);

    generate
        if (DIV < DIV_MIN || DIV > DIV_MAX) begin : g_bad_div
            $error("pll_clk_div: DIV=%0d outside legal range %0d..%0d", DIV, DIV_MIN, DIV_MAX);
        end
    endgenerate

    localparam logic [DIV_W-1:0] c_last = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] c_half = DIV_W'(DIV / 2);

    logic [DIV_W-1:0] r_cnt;
    logic             r_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else if (!en) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else begin
            // Output reflects the pre-increment count, so c=0 is the first
            // high cycle once enabled.
            r_out <= (r_cnt < c_half);
            r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
        end
    end

    assign clk_o = r_out;

endmodule : pll_clk_div
`default_nettype wire

// File: rtl/pll_clkgen.sv
`default_nettype none
// ============================================================================
//  Module      : pll_clkgen
//  Description : Synthesizable digital stand-in for the board PLL. Divides
//                clkin1 by two fixed integer ratios and raises a monotonic
//                lock flag LOCK_CYCLES edges after internal reset release.
//                Reset deassertion passes through a 2-flop synchroniser, so
//                the lock counter starts on the 3rd clkin1 edge after rst_n
//                rises and pll_lock sets on edge LOCK_CYCLES+2.
//  Ports       : clkin1   - reference clock, the only clock of the block
//                rst_n    - asynchronous active-low reset
//                clkout0  - clkin1 / CLKOUT0_DIV
//                clkout1  - clkin1 / CLKOUT1_DIV
//                pll_lock - registered lock indicator, one rise per reset
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_clkgen
    import pll_clkgen_pkg::*;
#(
    parameter real CLKIN_FREQ  = 50.0,
    parameter int  CLKOUT0_DIV = 2,
    parameter int  CLKOUT1_DIV = 4,
    parameter int  LOCK_CYCLES = 1024
) (
    input  logic clkin1,
    input  logic rst_n,
    output logic clkout0,
    output logic clkout1,
    output logic pll_lock
);

    generate
        if (LOCK_CYCLES < 1 || LOCK_CYCLES > LOCK_MAX) begin : g_bad_lock
            $error("pll_clkgen: LOCK_CYCLES=%0d outside legal range 1..%0d", LOCK_CYCLES, LOCK_MAX);
        end
        if (CLKIN_FREQ <= 0.0) begin : g_bad_freq
            $error("pll_clkgen: CLKIN_FREQ must be positive");
        end
    endgenerate

    localparam logic [LOCK_W-1:0] c_lock_last = LOCK_W'(LOCK_CYCLES - 1);

    logic [1:0]        r_rst_sync;
    logic [LOCK_W-1:0] r_lock_cnt;
    logic              r_lock;

    // Assert asynchronously, release synchronously after two clkin1 edges
    always_ff @(posedge clkin1 or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    // Lock counter saturates once r_lock is set; only rst_n can clear it,
    // which keeps pll_lock monotonic within a reset epoch.
    always_ff @(posedge clkin1 or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_cnt <= '0;
            r_lock     <= 1'b0;
        end else if (r_rst_sync[1] && !r_lock) begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
            if (r_lock_cnt == c_lock_last) begin
                r_lock <= 1'b1;
            end
        end
    end

    // Both dividers share the enable, so they leave reset on the same edge
    // and stay phase-aligned at c=0.
    pll_clk_div #(
        .DIV   (CLKOUT0_DIV)
    ) u_div0 (
        .clk   (clkin1),
        .rst_n (rst_n),
        .en    (r_lock),
        .clk_o (clkout0)
    );

    pll_clk_div #(
        .DIV   (CLKOUT1_DIV)
    ) u_div1 (
        .clk   (clkin1),
        .rst_n (rst_n),
        .en    (r_lock),
        .clk_o (clkout1)
    );

    assign pll_lock = r_lock;

endmodule : pll_clkgen
`default_nettype wire

// File: tb/tb_pll_clkgen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pll_clkgen
//  Description : Self-checking bench for pll_clkgen. Two instances share the
//                50 MHz clock and reset: dut_a uses the default ratios
//                (2, 4, lock 1024), dut_b uses odd ratios (3, 5) and the
//                minimum lock count of 1. Expected outputs come from a
//                closed-form model of edges counted since rst_n rose.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_clkgen;

    localparam int LA  = 1024;
    localparam int DA0 = 2;
    localparam int DA1 = 4;
    localparam int LB  = 1;
    localparam int DB0 = 3;
    localparam int DB1 = 5;

    logic clk  = 1'b0;
    logic sclk = 1'b0;
    logic rst_n;
    logic a_c0, a_c1, a_lock;
    logic b_c0, b_c1, b_lock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         k;
        logic [5:0] exp;
        logic [5:0] obs;
    } sb_item_t;

    sb_item_t sb_q[$];

    int k = 0;              // clkin1 rising edges since rst_n last rose
    int rises = 0;          // pll_lock rises seen by the 500 MHz sampler
    int lows_after = 0;     // low samples of pll_lock after its rise
    logic prev_lock = 1'b0;
    longint rise_time = 0;
    longint t_rel = 0;

    pll_clkgen #(
        .CLKIN_FREQ  (50.0),
        .CLKOUT0_DIV (DA0),
        .CLKOUT1_DIV (DA1),
        .LOCK_CYCLES (LA)
    ) dut_a (
        .clkin1   (clk),
        .rst_n    (rst_n),
        .clkout0  (a_c0),
        .clkout1  (a_c1),
        .pll_lock (a_lock)
    );

    pll_clkgen #(
        .CLKIN_FREQ  (50.0),
        .CLKOUT0_DIV (DB0),
        .CLKOUT1_DIV (DB1),
        .LOCK_CYCLES (LB)
    ) dut_b (
        .clkin1   (clk),
        .rst_n    (rst_n),
        .clkout0  (b_c0),
        .clkout1  (b_c1),
        .pll_lock (b_lock)
    );

    always #10 clk  = ~clk;   // 50 MHz, rising edges at 10, 30, 50 ...
    always #1  sclk = ~sclk;  // 500 MHz independent sampler, odd-ns edges

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    always @(posedge sclk) begin
        if (!rst_n) begin
            rises      <= 0;
            lows_after <= 0;
            prev_lock  <= 1'b0;
        end else begin
            if (a_lock && !prev_lock) begin
                rises     <= rises + 1;
                rise_time <= $time;
            end
            if (!a_lock && rises > 0) lows_after <= lows_after + 1;
            prev_lock <= a_lock;
        end
    end

    function automatic logic div_out(int kk, int lck, int dv);
        if (kk < lck + 3) return 1'b0;
        return ((kk - (lck + 3)) % dv) < (dv / 2);
    endfunction

    function automatic logic [5:0] model(int kk);
        logic la, lb;
        la = (kk >= LA + 2);
        lb = (kk >= LB + 2);
        return {la, div_out(kk, LA, DA0), div_out(kk, LA, DA1),
                lb, div_out(kk, LB, DB0), div_out(kk, LB, DB1)};
    endfunction

    // Advance n clkin1 cycles, queueing the model expectation and the DUT
    // outputs sampled 1 ns after each rising edge.
    task automatic advance(int n);
        sb_item_t it;
        repeat (n) begin
            @(posedge clk);
            #1;
            it.k   = k;
            it.exp = model(k);
            it.obs = {a_lock, a_c0, a_c1, b_lock, b_c0, b_c1};
            sb_q.push_back(it);
        end
    endtask

    task automatic test_reset();
        sb_item_t it;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_lock, a_c0, a_c1, b_lock, b_c0, b_c1} !== 6'b0) begin
            errors++;
            $display("FAIL reset_initial observed=%b required=000000",
                     {a_lock, a_c0, a_c1, b_lock, b_c0, b_c1});
        end
        advance(4);
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            checks++;
            if (it.obs !== it.exp) begin
                errors++;
                $display("FAIL reset_hold k=%0d observed=%b required=%b", it.k, it.obs, it.exp);
            end
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        t_rel = $time;
    endtask

    task automatic check_lock_time(string name);
        longint want;
        want = longint'((LA + 2) * 20 - 9);
        checks++;
        if (rises != 1 || (rise_time - t_rel) != want) begin
            errors++;
            $display("FAIL %s rises=%0d delay=%0d ns required rises=1 delay=%0d ns",
                     name, rises, rise_time - t_rel, want);
        end
    endtask

    task automatic test_lock();
        sb_item_t it;
        release_reset();
        advance(LA + 4);
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            checks++;
            if (it.obs !== it.exp) begin
                errors++;
                $display("FAIL lock_seq k=%0d observed=%b required=%b", it.k, it.obs, it.exp);
            end
        end
        check_lock_time("lock_delay");
    endtask

    task automatic test_dividers();
        sb_item_t it;
        advance(60);
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            checks++;
            if (it.obs !== it.exp) begin
                errors++;
                $display("FAIL dividers k=%0d observed=%b required=%b", it.k, it.obs, it.exp);
            end
        end
    endtask

    task automatic test_lock_stability();
        sb_item_t it;
        advance(2000);
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            checks++;
            if (it.obs !== it.exp) begin
                errors++;
                $display("FAIL stability k=%0d observed=%b required=%b", it.k, it.obs, it.exp);
            end
        end
        checks++;
        if (rises != 1 || lows_after != 0) begin
            errors++;
            $display("FAIL lock_stable rises=%0d low_samples=%0d required 1 and 0", rises, lows_after);
        end
    endtask

    task automatic test_reset_mid();
        sb_item_t it;
        // Assert between clock edges: outputs must clear without a clkin1 edge
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_lock, a_c0, a_c1, b_lock, b_c0, b_c1} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset observed=%b required=000000",
                     {a_lock, a_c0, a_c1, b_lock, b_c0, b_c1});
        end
        #96;
        release_reset();
        advance(LA + 12);
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            checks++;
            if (it.obs !== it.exp) begin
                errors++;
                $display("FAIL relock k=%0d observed=%b required=%b", it.k, it.obs, it.exp);
            end
        end
        check_lock_time("relock_delay");
    endtask

    task automatic test_early_reset();
        sb_item_t it;
        @(negedge clk);
        rst_n = 1'b0;
        #40;
        release_reset();
        advance(502);      // lock counter of dut_a at 500
        @(negedge clk);
        rst_n = 1'b0;
        #40;
        release_reset();
        advance(LA + 8);
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            checks++;
            if (it.obs !== it.exp) begin
                errors++;
                $display("FAIL early_reset k=%0d observed=%b required=%b", it.k, it.obs, it.exp);
            end
        end
        check_lock_time("early_reset_delay");
    endtask

    initial begin
        test_reset();
        test_lock();
        test_dividers();
        test_lock_stability();
        test_reset_mid();
        test_early_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pll_clkgen
`default_nettype wire

// File: doc/pll_clkgen.md
Name: pll_clkgen

Overview:
- Synthesizable digital stand-in for the board PLL that feeds the RISC-V SoC clock tree.
- Takes the 50 MHz board clock and produces two integer-divided clocks, clkout0 and clkout1, plus a monotonic pll_lock flag.
- Downstream reset logic releases the core on pll_lock.
- It is not an analogue model: it cannot multiply frequency, it only divides and delays lock.

Parameters:
- CLKIN_FREQ, 50.0: nominal input frequency in MHz. Documentation and assertions only; no effect on logic.
- CLKOUT0_DIV, 2: integer divide ratio clkin1 -> clkout0. Legal range 2..1023.
- CLKOUT1_DIV, 4: integer divide ratio clkin1 -> clkout1. Legal range 2..1023.
- LOCK_CYCLES, 1024: clkin1 rising edges after reset release before pll_lock asserts. Legal range 1..65535.

Ports:
- clkin1, input, 1: reference clock and the only clock of the block, 50 MHz.
- rst_n, input, 1: asynchronous active-low reset. In the system it is driven from the global reset (GRS_N); tie to 1 when unused.
- clkout0, output, 1: divided clock 0.
- clkout1, output, 1: divided clock 1.
- pll_lock, output, 1: lock indicator, registered.

Behaviour:
Reset
- rst_n low forces, asynchronously: clkout0=0, clkout1=0, pll_lock=0, all counters=0.
- Deassertion is synchronised internally by a 2-flop synchroniser on clkin1, so internal release occurs on the 2nd clkin1 rising edge after rst_n rises.

Lock counter
- Starts counting clkin1 rising edges after internal release.
- pll_lock goes 1 on the edge the count reaches LOCK_CYCLES.
- The counter then saturates and pll_lock stays 1 until the next rst_n assertion. It never toggles, so there is exactly one rising edge per reset.
- Reset asserted mid-count clears the count, and counting restarts from 0 on release.

Dividers (one per output, identical)
- Each divider holds a counter c in 0..DIV-1, incremented on every clkin1 rising edge and wrapping from DIV-1 to 0.
- Output register = 1 when c < DIV/2 (integer division), else 0.
  - Even DIV gives 50% duty.
  - Odd DIV gives high for floor(DIV/2) cycles and low for the rest.
- Divider counters are held at 0 with their outputs at 0 while pll_lock=0.
- Counting starts on the first edge after pll_lock=1, so the first high phase is a full half-period (no runt pulse).
- Both outputs start on the same clkin1 edge and are therefore phase-aligned at c=0.
- Outputs are registered (glitch-free) and change only on clkin1 rising edges. Period = DIV × clkin1 period.

Other rules
- No dynamic reconfiguration inputs; divide ratios are fixed at elaboration.
- Illegal parameter values (DIV<2, LOCK_CYCLES=0) stop elaboration with an error.

Decomposition:
- Package pll_clkgen_pkg holds:
  - constants DIV_MIN=2, DIV_MAX=1023;
  - localparam widths DIV_W=10, LOCK_W=16.
- Sub-module pll_clk_div (parameter DIV; ports clk, rst_n, en, clk_o) is instantiated twice.
- The top level contains the reset synchroniser and the lock counter.

Test Plan:
- Reset then lock: 50 MHz clkin1; rst_n low 20 ns then high.
  - Required: outputs and lock stay 0 during reset.
  - Required: pll_lock rises exactly (LOCK_CYCLES+2)×20 ns after release (20.52 µs with defaults).
- Lock stability: run 4 ms after lock, sampling pll_lock with an independent 500 MHz clock.
  - Required: exactly one rising edge and no low samples after the rise.
- Frequencies with defaults, after lock:
  - clkout0 period = 40 ns with 20 ns high;
  - clkout1 period = 80 ns with 40 ns high;
  - both rise on the same clkin1 edge, the first edge after lock.
- Odd divide, CLKOUT1_DIV=5: clkout1 period = 100 ns, high 40 ns, low 60 ns.
- Reset mid-operation: assert rst_n low at 30 µs for 100 ns.
  - Required: all outputs go to 0 immediately and asynchronously.
  - Required: pll_lock re-rises 20.52 µs after release; clkout0 and clkout1 restart from a full high phase.
- Early reset: pulse rst_n low at count 500 of LOCK_CYCLES.
  - Required: lock counter restarts; pll_lock stays 0 for a full LOCK_CYCLES after release.
